rr_encoder_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 8-to-3 encoder-indexed resource among N requesters.

---
 rtl/rr_encoder_arbiter_if.sv | 28 ++
 rtl/rr_encoder_arbiter.sv | 141 ++++++++++++++
 tb/tb_rr_encoder_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface rr_encoder_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic             timeout;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_vld,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_vld,
    output timeout
  );
endinterface

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and its encoded index.
// Optional forced release after HOLD_MAX busy cycles: define ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant, waiting for any request
// BUSY  | grant held for the winner while it keeps requesting
// GAP   | one grant-free turnaround cycle after a release
module rr_encoder_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int HOLD_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_encoder_arbiter_if.slave arb
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  if (N != (1 << IDX_W)) begin : g_bad_width
    $error("rr_encoder_arbiter: N must equal 2**IDX_W");
  end
  if (HOLD_MAX < 2) begin : g_bad_hold
    $error("rr_encoder_arbiter: HOLD_MAX must be at least 2");
  end

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Scan from ptr upward, wrapping naturally because N is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!win_found && arb.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_BUSY: begin
        if (!arb.req[idx_q]) begin
          state_d = S_GAP;
          grant_d = '0;
          idx_d   = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == HOLD_LAST) begin
          state_d   = S_GAP;
          grant_d   = '0;
          idx_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_IDLE, S_GAP: begin
        if (win_found) begin
          state_d = S_BUSY;
          grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
          idx_d   = win_idx;
          ptr_d   = win_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign arb.grant     = grant_q;
  assign arb.grant_idx = idx_q;
  assign arb.grant_vld = |grant_q;
`ifdef ARB_TIMEOUT_EN
  assign arb.timeout   = timeout_q;
`else
  assign arb.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter: reset, rotation, wrap, hold, async reset, idle.
module tb_rr_encoder_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   errs;

  rr_encoder_arbiter_if #(.N(8), .IDX_W(3)) arb_if_i ();

  rr_encoder_arbiter #(.N(8), .IDX_W(3), .HOLD_MAX(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb_if_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset(input logic [7:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    arb_if_i.req = r;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    arb_if_i.req = 8'hFF;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h00 || arb_if_i.grant_idx !== 3'd0 || arb_if_i.grant_vld !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: grant=%h idx=%0d vld=%b, expected 00/0/0",
               arb_if_i.grant, arb_if_i.grant_idx, arb_if_i.grant_vld);
    end
    tests++;
    if (arb_if_i.timeout !== 1'b0) begin
      errs++;
      $display("FAIL reset_timeout: timeout=%b, expected 0", arb_if_i.timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h01 || arb_if_i.grant_idx !== 3'd0 || arb_if_i.grant_vld !== 1'b1) begin
      errs++;
      $display("FAIL reset_first_grant: grant=%h idx=%0d vld=%b, expected 01/0/1",
               arb_if_i.grant, arb_if_i.grant_idx, arb_if_i.grant_vld);
    end
  endtask

  task automatic test_rotation;
    logic [7:0] exp_g;
    logic [2:0] exp_i;
    apply_reset(8'hFF);
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      exp_i = 3'(k % 8);
      exp_g = 8'h01 << exp_i;
      for (int c = 0; c < 3; c++) begin
        tests++;
        if (arb_if_i.grant !== exp_g || arb_if_i.grant_idx !== exp_i || arb_if_i.grant_vld !== 1'b1) begin
          errs++;
          $display("FAIL rotation_grant k=%0d c=%0d: grant=%h idx=%0d vld=%b, expected %h/%0d/1",
                   k, c, arb_if_i.grant, arb_if_i.grant_idx, arb_if_i.grant_vld, exp_g, exp_i);
        end
        if (c == 2) arb_if_i.req[exp_i] = 1'b0;
        @(negedge clk);
      end
      tests++;
      if (arb_if_i.grant !== 8'h00 || arb_if_i.grant_vld !== 1'b0 || arb_if_i.grant_idx !== 3'd0) begin
        errs++;
        $display("FAIL rotation_gap k=%0d: grant=%h vld=%b idx=%0d, expected 00/0/0",
                 k, arb_if_i.grant, arb_if_i.grant_vld, arb_if_i.grant_idx);
      end
      arb_if_i.req[exp_i] = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_wrap_skip;
    apply_reset(8'h20);
    @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h20) begin
      errs++;
      $display("FAIL wrap_setup: grant=%h, expected 20", arb_if_i.grant);
    end
    arb_if_i.req = 8'h05;
    @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h00) begin
      errs++;
      $display("FAIL wrap_gap: grant=%h, expected 00", arb_if_i.grant);
    end
    @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h01 || arb_if_i.grant_idx !== 3'd0) begin
      errs++;
      $display("FAIL wrap_first: grant=%h idx=%0d, expected 01/0", arb_if_i.grant, arb_if_i.grant_idx);
    end
    arb_if_i.req = 8'h04;
    repeat (2) @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h04 || arb_if_i.grant_idx !== 3'd2) begin
      errs++;
      $display("FAIL wrap_skip: grant=%h idx=%0d, expected 04/2", arb_if_i.grant, arb_if_i.grant_idx);
    end
    arb_if_i.req = 8'h09;
    repeat (2) @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h08 || arb_if_i.grant_idx !== 3'd3) begin
      errs++;
      $display("FAIL wrap_ptr_priority: grant=%h idx=%0d, expected 08/3", arb_if_i.grant, arb_if_i.grant_idx);
    end
  endtask

  task automatic test_hold;
`ifdef ARB_TIMEOUT_EN
    apply_reset(8'h18);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      tests++;
      if (arb_if_i.grant !== 8'h08 || arb_if_i.grant_idx !== 3'd3 || arb_if_i.timeout !== 1'b0) begin
        errs++;
        $display("FAIL hold_timeout_busy c=%0d: grant=%h idx=%0d timeout=%b, expected 08/3/0",
                 c, arb_if_i.grant, arb_if_i.grant_idx, arb_if_i.timeout);
      end
    end
    @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h00 || arb_if_i.timeout !== 1'b1) begin
      errs++;
      $display("FAIL hold_timeout_pulse: grant=%h timeout=%b, expected 00/1", arb_if_i.grant, arb_if_i.timeout);
    end
    @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h10 || arb_if_i.grant_idx !== 3'd4 || arb_if_i.timeout !== 1'b0) begin
      errs++;
      $display("FAIL hold_timeout_next: grant=%h idx=%0d timeout=%b, expected 10/4/0",
               arb_if_i.grant, arb_if_i.grant_idx, arb_if_i.timeout);
    end
`else
    apply_reset(8'h10);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tests++;
      if (arb_if_i.grant !== 8'h10 || arb_if_i.grant_idx !== 3'd4 || arb_if_i.timeout !== 1'b0) begin
        errs++;
        $display("FAIL hold c=%0d: grant=%h idx=%0d timeout=%b, expected 10/4/0",
                 c, arb_if_i.grant, arb_if_i.grant_idx, arb_if_i.timeout);
      end
    end
`endif
  endtask

  task automatic test_async_reset;
    apply_reset(8'h20);
    @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h20 || arb_if_i.grant_idx !== 3'd5) begin
      errs++;
      $display("FAIL async_setup: grant=%h idx=%0d, expected 20/5", arb_if_i.grant, arb_if_i.grant_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (arb_if_i.grant !== 8'h00 || arb_if_i.grant_vld !== 1'b0 || arb_if_i.grant_idx !== 3'd0) begin
      errs++;
      $display("FAIL async_drop: grant=%h vld=%b idx=%0d, expected 00/0/0",
               arb_if_i.grant, arb_if_i.grant_vld, arb_if_i.grant_idx);
    end
    arb_if_i.req = 8'h60;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h20 || arb_if_i.grant_idx !== 3'd5) begin
      errs++;
      $display("FAIL async_ptr_restart: grant=%h idx=%0d, expected 20/5", arb_if_i.grant, arb_if_i.grant_idx);
    end
  endtask

  task automatic test_idle;
    apply_reset(8'h00);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (arb_if_i.grant !== 8'h00 || arb_if_i.grant_vld !== 1'b0) begin
        errs++;
        $display("FAIL idle c=%0d: grant=%h vld=%b, expected 00/0", c, arb_if_i.grant, arb_if_i.grant_vld);
      end
    end
    arb_if_i.req = 8'h80;
    @(negedge clk);
    tests++;
    if (arb_if_i.grant !== 8'h80 || arb_if_i.grant_idx !== 3'd7 || arb_if_i.grant_vld !== 1'b1) begin
      errs++;
      $display("FAIL idle_wake: grant=%h idx=%0d vld=%b, expected 80/7/1",
               arb_if_i.grant, arb_if_i.grant_idx, arb_if_i.grant_vld);
    end
  endtask

  initial begin
    tests = 0;
    errs  = 0;
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_hold();
    test_async_reset();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
